print_arbiter: RTL and testbench
================================

# print_arbiter

- Shares the six-digit 7-segment decimal display between `N_REQ` requesters, each presenting a 20-bit unsigned value.
- Round-robin scheduler: grants one requester at a time and latches its value.
- Sequential binary-to-BCD conversion by shift-add-3, 20 cycles; replaces the combinational divide/modulo path.
- Leading-zero blanking, then drives registered `DIGITS`/`HEX` for `HOLD_CYCLES` before servicing the next requester.

## Interface

- `N_REQ`, 4: number of requesters, ≥1.
- `HOLD_CYCLES`, 50_000_000: cycles each result stays displayed before re-arbitration, ≥1.
- `HOLD_W`, 26: hold counter width, ≥ clog2(`HOLD_CYCLES`+1).

Ports:

- `CLK` in 1: single clock; all state updates on rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `REQ` in `N_REQ`: per-requester display request, level-sensitive.
- `VALUE` in 20*`N_REQ`: requester i at `VALUE[20i+19:20i]`, unsigned.
- `GRANT` out `N_REQ`: one-hot, requester whose value is being converted or shown.
- `BUSY` out 1: high while converting or blanking.
- `OVF` out 1: displayed value was saturated.
- `DIGITS` out 24: six BCD nibbles; digit d at `[4d+3:4d]`; 4'hF = blank.
- `HEX` out 42: digit d at `[7d+6:7d]`, bit order gfedcba (bit 0 = a), active-low; blank = 7'b1111111.

## Operation

- **States:** IDLE, CONV, SUPP, SHOW.
- **Reset values:** state IDLE; `GRANT`=0, `BUSY`=0, `OVF`=0, `DIGITS`=24'hFFFFFF, `HEX` all ones; rr pointer = `N_REQ`-1.
- **Arbitration edge** (in IDLE, or the final SHOW edge):
  - If `REQ`≠0, pick the first set bit searching from pointer+1 modulo `N_REQ`.
  - Set `GRANT` one-hot and the pointer to the winner.
  - Latch the winner's VALUE, saturated: >999_999 loads 999_999 and a pending overflow flag.
  - Clear the BCD accumulator; go to CONV.
  - If `REQ`=0: IDLE, `GRANT`=0, display retained.
- **CONV:** 20 iterations. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. After iteration 20 go to SUPP.
- **SUPP:** one cycle; computes blanking.
  - Nibbles above the most significant nonzero digit become 4'hF.
  - Value 0 shows a single "0" in digit 0 (24'hFFFFF0).
- **SUPP→SHOW edge:** registers `DIGITS`, `HEX` (decode 0–9 standard; F→blank) and `OVF` from the pending flag.
- **SHOW:** hold counter runs `HOLD_CYCLES` cycles; the last edge is an arbitration edge.
- **Input changes after latch:** `REQ` deassertion and `VALUE` changes are ignored; the conversion completes and is shown for the full hold.
- **Single persistent requester:** re-latched and re-converted every hold period, so value updates appear at hold granularity.
- **Decoder:** non-BCD nibbles other than F never occur; the decoder maps them to blank.

## Timing

- Arbitration edge = E0. `GRANT`/`BUSY` valid after E0.
- Edges E1..E20: conversion shifts. After E20 the state is SUPP.
- E21: `DIGITS`/`HEX`/`OVF` update; `BUSY` falls; state SHOW.
- `BUSY` is high for exactly 21 cycles.
- Next arbitration edge is E21+`HOLD_CYCLES`. Back-to-back requester service period is 21+`HOLD_CYCLES` cycles.
- `GRANT` is continuous across back-to-back service, changing only at arbitration edges.
- Display outputs change only at SUPP→SHOW edges and on reset.
- `RESET` high at any edge, any state: all outputs take reset values after that edge; the in-flight conversion is discarded.
- `RESET` and `REQ` high on the same edge: reset wins.

## Test plan

- **Reset:** assert `RESET` mid-CONV → after the edge: `HEX`=42'h3FFFFFFFFFF, `DIGITS`=24'hFFFFFF, `GRANT`=0, `BUSY`=0, `OVF`=0; state IDLE.
- **Single value:** `REQ`=4'b0001, VALUE0=12345, `HOLD_CYCLES`=4 →
  - `GRANT`=0001 after E0; `BUSY` high 21 cycles.
  - After E21: `DIGITS`=24'hF12345, digit5 `HEX`=7'b1111111, digit0 `HEX`=7'b0010010, `OVF`=0.
- **Zero:** VALUE0=0 → `DIGITS`=24'hFFFFF0, digit0 `HEX`=7'b1000000. **Max in range:** VALUE0=999_999 → `DIGITS`=24'h999999, `OVF`=0.
- **Saturation:** VALUE0=1_048_575 → `DIGITS`=24'h999999, `OVF`=1. A following request with VALUE0=7 → `DIGITS`=24'hFFFFF7, `OVF`=0.
- **Round robin:** `HOLD_CYCLES`=4, `REQ`=4'b1011 held → `GRANT` sequence 0001, 0010, 1000, 0001, each change 25 cycles apart.
- **Mid-operation changes and idle:**
  - `REQ` dropped and VALUE0 changed at E5 → original value still displayed for the full hold.
  - Then `REQ`=0 → `GRANT`=0, display unchanged.

Source files
------------

// File: rtl/print_arbiter.sv
// ---------------------------------------------------------------------------
// print_arbiter
//
// Shares one six-digit 7-segment decimal display between N_REQ requesters.
// A round-robin scheduler grants one requester and latches its 20-bit value,
// saturated to 999_999. The value is converted to BCD by shift-add-3 over 20
// cycles. Leading zeros are then blanked, and the result is held on the
// display for HOLD_CYCLES cycles before the next requester is serviced.
//
// Ports:
//   CLK     - single clock, all state changes on the rising edge
//   RESET   - synchronous, active-high reset
//   REQ     - per-requester display request, level-sensitive
//   VALUE   - requester i value at VALUE[20i+19:20i], unsigned
//   GRANT   - one-hot requester being converted or shown (0 when idle)
//   BUSY    - high while converting or blanking
//   OVF     - displayed value was saturated
//   DIGITS  - six BCD nibbles, digit d at [4d+3:4d], 4'hF = blank
//   HEX     - digit d at [7d+6:7d], gfedcba active-low, blank = 7'b1111111
// ---------------------------------------------------------------------------
module print_arbiter #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int HOLD_W      = 26
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [20*N_REQ-1:0]   VALUE,
    output logic [N_REQ-1:0]      GRANT,
    output logic                  BUSY,
    output logic                  OVF,
    output logic [23:0]           DIGITS,
    output logic [41:0]           HEX
);

    localparam int                PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [19:0]       MAX_VAL   = 20'd999_999;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [4:0]        LAST_ITER = 5'd19;

    typedef enum logic [1:0] {IDLE, CONV, SUPP, SHOW} state_t;

    state_t              state_q,    state_d;
    logic [PTR_W-1:0]    ptr_q,      ptr_d;
    logic [N_REQ-1:0]    grant_q,    grant_d;
    logic                busy_q,     busy_d;
    logic                ovf_q,      ovf_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [23:0]         digits_q,   digits_d;
    logic [41:0]         hex_q,      hex_d;
    logic [19:0]         bin_q,      bin_d;
    logic [23:0]         bcd_q,      bcd_d;
    logic [4:0]          iter_q,     iter_d;
    logic [HOLD_W-1:0]   hold_q,     hold_d;

    logic                arb_found;
    logic [PTR_W-1:0]    arb_idx;
    logic [PTR_W-1:0]    arb_cand;
    logic [19:0]         arb_value;
    logic [N_REQ-1:0]    arb_onehot;
    logic [23:0]         bcd_adj;
    logic [23:0]         bcd_shift;
    logic [19:0]         bin_shift;
    logic [23:0]         blank_digits;
    logic [41:0]         blank_hex;
    logic                leading;
    logic                do_arb;

    // Standard 7-segment decode, gfedcba active-low; anything that is not a
    // decimal digit (including the 4'hF blank code) turns every segment off.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Round-robin pick: scan from the requester after the last winner,
    // wrapping, and take the first one asking. The winner's value is muxed
    // out with constant slices so no variable part-select is needed.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = '0;
        arb_cand   = '0;
        arb_value  = '0;
        arb_onehot = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            arb_cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!arb_found && REQ[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_idx == PTR_W'(i)) begin
                arb_value     = VALUE[20*i +: 20];
                arb_onehot[i] = 1'b1;
            end
        end
    end

    // One double-dabble iteration: correct every nibble that would overflow
    // past 9 after doubling, then shift the binary MSB into the BCD LSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < 6; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[22:0], bin_q[19]};
        bin_shift = {bin_q[18:0], 1'b0};
    end

    // Leading-zero blanking from the top digit down. Digit 0 is never
    // blanked, so a zero value naturally shows a single "0".
    always_comb begin
        blank_digits = bcd_q;
        leading      = 1'b1;
        for (int d = 5; d >= 1; d--) begin
            if (leading && (bcd_q[4*d +: 4] == 4'd0)) begin
                blank_digits[4*d +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
        for (int d = 0; d < 6; d++) begin
            blank_hex[7*d +: 7] = seg7(blank_digits[4*d +: 4]);
        end
    end

    // Next-state logic. IDLE and the final SHOW cycle share the same
    // arbitration step; with nobody requesting, the display is left as is.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        hex_d      = hex_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        hold_d     = hold_q;
        do_arb     = 1'b0;

        case (state_q)
            IDLE: do_arb = 1'b1;
            CONV: begin
                bcd_d  = bcd_shift;
                bin_d  = bin_shift;
                iter_d = iter_q + 5'd1;
                if (iter_q == LAST_ITER) begin
                    state_d = SUPP;
                end
            end
            SUPP: begin
                digits_d = blank_digits;
                hex_d    = blank_hex;
                ovf_d    = ovf_pend_q;
                busy_d   = 1'b0;
                hold_d   = '0;
                state_d  = SHOW;
            end
            SHOW: begin
                if (hold_q == HOLD_LAST) begin
                    do_arb = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_arb) begin
            if (arb_found) begin
                grant_d    = arb_onehot;
                ptr_d      = arb_idx;
                ovf_pend_d = (arb_value > MAX_VAL);
                bin_d      = (arb_value > MAX_VAL) ? MAX_VAL : arb_value;
                bcd_d      = '0;
                iter_d     = '0;
                busy_d     = 1'b1;
                state_d    = CONV;
            end else begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    // State and registered outputs; reset discards any in-flight conversion.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            ptr_q      <= PTR_W'(N_REQ - 1);
            grant_q    <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            digits_q   <= 24'hFFFFFF;
            hex_q      <= '1;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            hex_q      <= hex_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            hold_q     <= hold_d;
        end
    end

    assign GRANT  = grant_q;
    assign BUSY   = busy_q;
    assign OVF    = ovf_q;
    assign DIGITS = digits_q;
    assign HEX    = hex_q;

endmodule

// File: tb/tb_print_arbiter.sv
// ---------------------------------------------------------------------------
// tb_print_arbiter
//
// Self-checking bench for print_arbiter with N_REQ=4, HOLD_CYCLES=4.
// A table of hand-derived vectors covers reset, zero, the in-range maximum,
// saturation and round robin. Hand-written sequences cover mid-operation
// input changes, going idle and reset mid-conversion. Randomized requests are
// then checked against a transaction-level model that works on decimal
// arithmetic.
// ---------------------------------------------------------------------------
module tb_print_arbiter;

    localparam int N_REQ       = 4;
    localparam int HOLD_CYCLES = 4;
    localparam int HOLD_W      = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [79:0] value;
    logic [3:0]  grant;
    logic        busy;
    logic        ovf;
    logic [23:0] digits;
    logic [41:0] hex;

    int          vectors = 0;
    int          miscompares = 0;

    logic [23:0] cur_digits;
    logic [41:0] cur_hex;
    logic        cur_ovf;
    int          model_ptr;

    typedef struct {
        logic [3:0]  req;
        logic [79:0] value;
        logic [3:0]  grant;
        logic [23:0] digits;
        logic        ovf;
        logic [6:0]  hex0;
        logic [6:0]  hex5;
    } vec_t;

    vec_t vecs[9];

    print_arbiter #(
        .N_REQ       (N_REQ),
        .HOLD_CYCLES (HOLD_CYCLES),
        .HOLD_W      (HOLD_W)
    ) dut (
        .CLK    (clk),
        .RESET  (reset),
        .REQ    (req),
        .VALUE  (value),
        .GRANT  (grant),
        .BUSY   (busy),
        .OVF    (ovf),
        .DIGITS (digits),
        .HEX    (hex)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge, where inputs are
    // driven and outputs sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [79:0] v);
        req   = r;
        value = v;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Segment patterns for a decimal display, gfedcba active-low.
    function automatic logic [6:0] refSeg(input logic [3:0] nib);
        logic [6:0] tbl[10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (nib <= 4'd9) return tbl[nib];
        return 7'h7F;
    endfunction

    // Expected display for a raw value: saturate, then emit decimal digits
    // while any significant digits remain; digit 0 always shows.
    function automatic logic [23:0] refDigits(input int v);
        int          s;
        logic [23:0] r;
        s = (v > 999_999) ? 999_999 : v;
        r = 24'hFFFFFF;
        for (int d = 0; d < 6; d++) begin
            if (d == 0 || s != 0) r[4*d +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return r;
    endfunction

    function automatic logic [41:0] refHex(input logic [23:0] dg);
        logic [41:0] h;
        for (int d = 0; d < 6; d++) h[7*d +: 7] = refSeg(dg[4*d +: 4]);
        return h;
    endfunction

    // One arbitration edge and everything up to the next one. With
    // exp_grant = 0 the edge must leave the block idle and the display
    // untouched. At cycle drop_at the inputs are replaced by drop_req and
    // drop_value, which must not affect the value being shown.
    task automatic runService(input logic [3:0] exp_grant, input logic [23:0] exp_digits,
                              input logic exp_ovf, input int drop_at,
                              input logic [3:0] drop_req, input logic [79:0] drop_value);
        int busy_len;
        tick();
        if (exp_grant == 4'b0000) begin
            checkOutput("idle_grant", 64'(grant), 64'(0));
            checkOutput("idle_busy", 64'(busy), 64'(0));
            checkOutput("idle_digits", 64'(digits), 64'(cur_digits));
            checkOutput("idle_hex", 64'(hex), 64'(cur_hex));
            checkOutput("idle_ovf", 64'(ovf), 64'(cur_ovf));
            return;
        end
        checkOutput("e0_grant", 64'(grant), 64'(exp_grant));
        checkOutput("e0_busy", 64'(busy), 64'(1));
        busy_len = 1;
        for (int c = 1; c <= 20; c++) begin
            if (c == drop_at) applyStimulus(drop_req, drop_value);
            tick();
            if (busy) busy_len++;
            checkOutput("conv_grant", 64'(grant), 64'(exp_grant));
            checkOutput("conv_digits_held", 64'(digits), 64'(cur_digits));
        end
        tick();
        checkOutput("busy_len", 64'(busy_len), 64'(21));
        checkOutput("show_busy", 64'(busy), 64'(0));
        checkOutput("show_digits", 64'(digits), 64'(exp_digits));
        checkOutput("show_hex", 64'(hex), 64'(refHex(exp_digits)));
        checkOutput("show_ovf", 64'(ovf), 64'(exp_ovf));
        checkOutput("show_grant", 64'(grant), 64'(exp_grant));
        cur_digits = exp_digits;
        cur_hex    = refHex(exp_digits);
        cur_ovf    = exp_ovf;
        for (int k = 1; k < HOLD_CYCLES; k++) begin
            tick();
            checkOutput("hold_digits", 64'(digits), 64'(cur_digits));
            checkOutput("hold_grant", 64'(grant), 64'(exp_grant));
        end
    endtask

    // Safety net so a stuck run still ends with a report.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  r_req;
        logic [79:0] r_val;
        int          win;
        int          idx;
        int          wv;

        vecs[0] = '{4'b0001, {20'd0, 20'd0, 20'd0, 20'd12345},        4'b0001, 24'hF12345, 1'b0, 7'b0010010, 7'b1111111};
        vecs[1] = '{4'b0001, {20'd0, 20'd0, 20'd0, 20'd0},            4'b0001, 24'hFFFFF0, 1'b0, 7'b1000000, 7'b1111111};
        vecs[2] = '{4'b0001, {20'd0, 20'd0, 20'd0, 20'd999999},       4'b0001, 24'h999999, 1'b0, 7'b0010000, 7'b0010000};
        vecs[3] = '{4'b0001, {20'd0, 20'd0, 20'd0, 20'd1048575},      4'b0001, 24'h999999, 1'b1, 7'b0010000, 7'b0010000};
        vecs[4] = '{4'b0001, {20'd0, 20'd0, 20'd0, 20'd7},            4'b0001, 24'hFFFFF7, 1'b0, 7'b1111000, 7'b1111111};
        vecs[5] = '{4'b1011, {20'd31000, 20'd0, 20'd100, 20'd5},      4'b0010, 24'hFFF100, 1'b0, 7'b1000000, 7'b1111111};
        vecs[6] = '{4'b1011, {20'd31000, 20'd0, 20'd100, 20'd5},      4'b1000, 24'hF31000, 1'b0, 7'b1000000, 7'b1111111};
        vecs[7] = '{4'b1011, {20'd31000, 20'd0, 20'd100, 20'd5},      4'b0001, 24'hFFFFF5, 1'b0, 7'b0010010, 7'b1111111};
        vecs[8] = '{4'b1011, {20'd31000, 20'd0, 20'd1000000, 20'd5},  4'b0010, 24'h999999, 1'b1, 7'b0010000, 7'b0010000};

        reset = 1'b1;
        applyStimulus(4'b0000, 80'd0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_grant", 64'(grant), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_ovf", 64'(ovf), 64'(0));
        checkOutput("reset_digits", 64'(digits), 64'(24'hFFFFFF));
        checkOutput("reset_hex", 64'(hex), 64'(42'h3FFFFFFFFFF));
        cur_digits = 24'hFFFFFF;
        cur_hex    = 42'h3FFFFFFFFFF;
        cur_ovf    = 1'b0;

        // Table of hand-derived services, back to back.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].req, vecs[i].value);
            runService(vecs[i].grant, vecs[i].digits, vecs[i].ovf, 0, 4'b0000, 80'd0);
            checkOutput("tbl_hex_digit0", 64'(hex[6:0]), 64'(vecs[i].hex0));
            checkOutput("tbl_hex_digit5", 64'(hex[41:35]), 64'(vecs[i].hex5));
        end

        // Request dropped and value changed mid-conversion, then idle.
        applyStimulus(4'b0001, {20'd0, 20'd0, 20'd0, 20'd4321});
        runService(4'b0001, 24'hFF4321, 1'b0, 5, 4'b0000, {20'd0, 20'd0, 20'd0, 20'd999});
        runService(4'b0000, cur_digits, cur_ovf, 0, 4'b0000, 80'd0);
        runService(4'b0000, cur_digits, cur_ovf, 0, 4'b0000, 80'd0);

        // Reset in the middle of a conversion while a request is still high.
        applyStimulus(4'b0001, {20'd0, 20'd0, 20'd0, 20'd55});
        tick();
        checkOutput("pre_reset_busy", 64'(busy), 64'(1));
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midconv_reset_grant", 64'(grant), 64'(0));
        checkOutput("midconv_reset_busy", 64'(busy), 64'(0));
        checkOutput("midconv_reset_ovf", 64'(ovf), 64'(0));
        checkOutput("midconv_reset_digits", 64'(digits), 64'(24'hFFFFFF));
        checkOutput("midconv_reset_hex", 64'(hex), 64'(42'h3FFFFFFFFFF));
        cur_digits = 24'hFFFFFF;
        cur_hex    = 42'h3FFFFFFFFFF;
        cur_ovf    = 1'b0;
        model_ptr  = N_REQ - 1;

        // Randomized requests against the transaction-level model.
        for (int n = 0; n < 16; n++) begin
            r_req = 4'($urandom_range(0, 15));
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 3) == 0) r_val[20*j +: 20] = 20'($urandom_range(999_990, 1_048_575));
                else                           r_val[20*j +: 20] = 20'($urandom_range(0, 999_999));
            end
            applyStimulus(r_req, r_val);
            win = -1;
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (model_ptr + k) % N_REQ;
                if (win < 0 && ((int'(r_req) >> idx) & 1) == 1) win = idx;
            end
            if (win < 0) begin
                runService(4'b0000, cur_digits, cur_ovf, 0, 4'b0000, 80'd0);
            end else begin
                model_ptr = win;
                wv = int'(r_val[20*win +: 20]);
                runService(4'(1 << win), refDigits(wv), (wv > 999_999), int'($urandom_range(1, 20)),
                           4'($urandom_range(0, 15)), {20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom)});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
